calc_ctrl_seq: RTL

Parametrised successor to the three-register calculator control unit. It adds an integrated X/Y/Z datapath of width W and two new opcodes, SUB and a multi-cycle MUL, which the original single-cycle decoder cannot express. Instruction issue uses a valid/ready handshake, and the block exposes an overflow flag and a completion pulse. It sits between the keypad/instruction front end and the display driver, which consumes Z.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_mul_seq.sv | 65 ++++++
 rtl/calc_ctrl_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode, register-control and ALU-op definitions for the
// calculator control sequencer and its multiplier.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_CLRLD = 3'b000,
        OP_ADDLD = 3'b001,
        OP_ADD   = 3'b010,
        OP_DIV2  = 3'b011,
        OP_DISP  = 3'b100,
        OP_SUB   = 3'b101,
        OP_MUL   = 3'b110,
        OP_NOP   = 3'b111
    } opcode_t;

    // Per-register control code produced by the decoder.
    typedef enum logic [1:0] {
        RC_HOLD  = 2'b00,
        RC_LOAD  = 2'b01,
        RC_SHR   = 2'b10,
        RC_CLEAR = 2'b11
    } regctl_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: iterative shift-add unsigned multiplier, one multiplier bit
// per cycle, W cycles per product.
//   clk, rst : clock, synchronous active-high reset
//   start    : latch a/b and begin (ignored while busy)
//   a, b     : multiplicand, multiplier (W bits)
//   busy     : multiplication in progress
//   valid    : combinational, high in the last iteration cycle; prod is final
//   prod     : 2W-bit product, valid together with valid
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           valid,
    output logic [2*W-1:0] prod
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_next;

    // The final partial sum is exposed combinationally so the caller can
    // commit it on the same edge that ends the last iteration.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign valid    = busy && (cnt == LAST);
    assign prod     = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_ctrl_seq.sv
// calc_ctrl_seq: calculator control unit with X/Y/Z datapath, valid/ready
// instruction issue, single-cycle ALU ops and a multi-cycle MUL.
//   clk, rst          : clock, synchronous active-high reset
//   instr, data_in    : opcode and operand, qualified by instr_valid
//   instr_valid/ready : issue handshake; accepted when both high at an edge
//   z_out             : display register Z
//   x_out, y_out      : debug views of X and Y
//   ovf               : carry/borrow/product-overflow of last arithmetic op
//   done              : one-cycle pulse after an instruction commits
//
// state   | meaning
// IDLE    | ready; non-MUL ops commit at the accepting edge
// MUL     | multiplier running, issue stalled until Y/ovf are written
module calc_ctrl_seq
    import calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] z_out,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         ovf,
    output logic         done
);

    state_t         state;
    logic [W-1:0]   x_q, y_q, z_q;
    opcode_t        op;
    regctl_t        x_ctl, y_ctl, z_ctl, ovf_ctl;
    logic           alu_op;
    logic [W:0]     alu_res;
    logic           accept, mul_start;
    logic           mul_busy, mul_valid;
    logic [2*W-1:0] mul_prod;

    assign op        = opcode_t'(instr);
    assign accept    = instr_valid && instr_ready;
    assign mul_start = accept && (op == OP_MUL);

    // ovf_ctl reuses the register-control codes: LOAD takes the ALU carry.
    always_comb begin
        x_ctl   = RC_HOLD;
        y_ctl   = RC_HOLD;
        z_ctl   = RC_HOLD;
        ovf_ctl = RC_HOLD;
        alu_op  = ALU_ADD;
        case (op)
            OP_CLRLD: begin x_ctl = RC_LOAD; y_ctl = RC_CLEAR; z_ctl = RC_CLEAR; ovf_ctl = RC_CLEAR; end
            OP_ADDLD: begin x_ctl = RC_LOAD; y_ctl = RC_LOAD; ovf_ctl = RC_LOAD; end
            OP_ADD:   begin y_ctl = RC_LOAD; ovf_ctl = RC_LOAD; end
            OP_DIV2:  begin y_ctl = RC_SHR; end
            OP_DISP:  begin z_ctl = RC_LOAD; x_ctl = RC_CLEAR; y_ctl = RC_CLEAR; end
            OP_SUB:   begin y_ctl = RC_LOAD; ovf_ctl = RC_LOAD; alu_op = ALU_SUB; end
            default:  ;
        endcase
    end

    // Bit W is the carry for ADD and the borrow (X > Y) for SUB.
    assign alu_res = (alu_op == ALU_SUB) ? ({1'b0, y_q} - {1'b0, x_q})
                                         : ({1'b0, y_q} + {1'b0, x_q});

    calc_mul_seq #(.W(W), .CNT_W(CNT_W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (y_q),
        .b     (x_q),
        .busy  (mul_busy),
        .valid (mul_valid),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state       <= ST_MUL;
                            instr_ready <= 1'b0;
                        end else begin
                            case (x_ctl)
                                RC_LOAD:  x_q <= data_in;
                                RC_SHR:   x_q <= x_q >> 1;
                                RC_CLEAR: x_q <= '0;
                                default:  ;
                            endcase
                            case (y_ctl)
                                RC_LOAD:  y_q <= alu_res[W-1:0];
                                RC_SHR:   y_q <= {1'b0, y_q[W-1:1]};
                                RC_CLEAR: y_q <= '0;
                                default:  ;
                            endcase
                            case (z_ctl)
                                RC_LOAD:  z_q <= y_q;
                                RC_CLEAR: z_q <= '0;
                                default:  ;
                            endcase
                            case (ovf_ctl)
                                RC_LOAD:  ovf <= alu_res[W];
                                RC_CLEAR: ovf <= 1'b0;
                                default:  ;
                            endcase
                            done <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_valid) begin
                        y_q         <= mul_prod[W-1:0];
                        ovf         <= |mul_prod[2*W-1:W];
                        done        <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (!mul_busy) begin
                        // Multiplier idle without a result: recover to IDLE.
                        instr_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;

endmodule
